// File: rtl/dl_shift_pkg.sv
// Shared types for the iterative shifter: operation codes and FSM states.
package dl_shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/dl_shift_step.sv
// One combinational shift step of 0..STEP positions.
// Rotate support is built only when DL_SHIFT_ITER_ROTATE_EN is defined.
module dl_shift_step
    import dl_shift_pkg::*;
#(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned STEP     = 2,
    parameter int unsigned AMT_W    = $clog2(STEP + 1)
) (
    input  logic [NUM_BITS-1:0] data,
    input  logic [AMT_W-1:0]    amt,
    input  shift_op_t           op,
    output logic [NUM_BITS-1:0] shifted
);

`ifdef DL_SHIFT_ITER_ROTATE_EN
    logic [2*NUM_BITS-1:0] dbl;
`endif

    always_comb begin
        shifted = data;
`ifdef DL_SHIFT_ITER_ROTATE_EN
        dbl = {data, data} << amt;
`endif
        case (op)
            SHIFT_SRL: shifted = data >> amt;
            // The MSB stays the original sign bit across steps, so each step refills with it
            SHIFT_SRA: shifted = NUM_BITS'($signed(data) >>> amt);
`ifdef DL_SHIFT_ITER_ROTATE_EN
            SHIFT_ROL: shifted = dbl[2*NUM_BITS-1:NUM_BITS];
`endif
            default:   shifted = data << amt;
        endcase
    end

endmodule

// File: rtl/dl_shift_iter.sv
// Multi-cycle shifter moving at most STEP bits per cycle under a valid/ready handshake.
// Optional ROL operation enabled by defining DL_SHIFT_ITER_ROTATE_EN.
module dl_shift_iter
    import dl_shift_pkg::*;
#(
    parameter  int unsigned NUM_BITS = 8,
    parameter  int unsigned STEP     = 2,
    localparam int unsigned SHIFT_W  = $clog2(NUM_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] in_a,
    input  logic [SHIFT_W-1:0]  in_shift,
    input  logic [1:0]          in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_data,
    output logic                busy
);

    localparam int unsigned AMT_W = $clog2(STEP + 1);

    shift_state_t          state;
    logic [NUM_BITS-1:0]   data_q;
    shift_op_t             op_q;
    logic [SHIFT_W-1:0]    rem_q;
    logic [AMT_W-1:0]      step_amt;
    logic [SHIFT_W-1:0]    rem_next;
    logic [NUM_BITS-1:0]   step_data;

    // k = min(remaining, STEP)
    always_comb begin
        if (32'(rem_q) > STEP) begin
            step_amt = AMT_W'(STEP);
        end else begin
            step_amt = AMT_W'(rem_q);
        end
        rem_next = rem_q - SHIFT_W'(step_amt);
    end

    dl_shift_step #(
        .NUM_BITS (NUM_BITS),
        .STEP     (STEP),
        .AMT_W    (AMT_W)
    ) u_step (
        .data    (data_q),
        .amt     (step_amt),
        .op      (op_q),
        .shifted (step_data)
    );

    assign out_data = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            op_q      <= SHIFT_SLL;
            rem_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_a;
                        op_q     <= shift_op_t'(in_op);
                        rem_q    <= in_shift;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_shift != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_data;
                    rem_q  <= rem_next;
                    if (rem_next == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/dl_shift_iter.md
DL_SHIFT_ITER -- requirements
Module: dl_shift_iter

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 8, data width; it SHALL be a power of two, 2 to 64.
REQ-002 The block SHALL have parameter STEP, default 2, maximum bit positions moved per cycle; it SHALL be a power of two, 1 to NUM_BITS.
REQ-003 The block SHALL derive localparam SHIFT_W = $clog2(NUM_BITS).
REQ-004 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, request valid.
REQ-007 The block SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-008 The block SHALL have port in_a, input, NUM_BITS, operand.
REQ-009 The block SHALL have port in_shift, input, SHIFT_W, shift amount, 0 to NUM_BITS-1.
REQ-010 The block SHALL have port in_op, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 The block SHALL have port out_valid, output, 1, result valid.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts the result when out_valid && out_ready.
REQ-013 The block SHALL have port out_data, output, NUM_BITS, result.
REQ-014 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 On an accept in IDLE, the block SHALL register in_a into the data register and latch in_op and in_shift into the op and remaining registers.
REQ-019 After an accept, the next state SHALL be SHIFT if in_shift != 0, otherwise DONE.
REQ-020 In SHIFT, each cycle SHALL shift the data register by k = min(remaining, STEP) and decrement remaining by k; the state SHALL move to DONE on the edge where remaining becomes 0.
REQ-021 Latency SHALL be out_valid asserted 1 + ceil(in_shift/STEP) cycles after the accept edge.
REQ-022 SLL and SRL SHALL zero-fill.
REQ-023 SRA SHALL fill with the original bit NUM_BITS-1 on every step.
REQ-024 ROL SHALL wrap bit NUM_BITS-1 into bit 0.
REQ-025 Bits shifted out SHALL be discarded.
REQ-026 In DONE, out_data SHALL hold stable until out_ready.
REQ-027 On out_valid && out_ready, the next state SHALL be IDLE; a new request SHALL be accepted no earlier than the following cycle, so there is no same-cycle re-accept.
REQ-028 in_valid in SHIFT or DONE SHALL be ignored, with no state change, and the requester SHALL hold its request.
REQ-029 Changes on in_a, in_shift and in_op after the accept SHALL NOT affect the result in progress.
REQ-030 out_data SHALL equal the data register in every state.

Reset
REQ-031 When rst_n = 0 at a rising clk edge, the state SHALL become IDLE, the data and remaining registers 0 and op SLL, from any state including mid-SHIFT, and any operation in flight SHALL be discarded with no output.
REQ-032 Values during reset SHALL be out_valid = 0, out_data = 0, busy = 0, in_ready = 1 from the first edge after rst_n falls.

Configuration
REQ-033 The macro DL_SHIFT_ITER_ROTATE_EN SHALL control the ROL operation.
REQ-034 With DL_SHIFT_ITER_ROTATE_EN defined, op 11 SHALL perform ROL.
REQ-035 Without DL_SHIFT_ITER_ROTATE_EN, op 11 SHALL decode as SLL and no rotate logic SHALL be built.

Structure
REQ-036 A shared package dl_shift_pkg SHALL hold typedef enum shift_op_t (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL) and typedef enum shift_state_t (ST_IDLE, ST_SHIFT, ST_DONE).
REQ-037 One combinational sub-module dl_shift_step SHALL perform one step (data, amount 0 to STEP, op in; shifted data out), instantiated once.
REQ-038 dl_shift_iter SHALL contain the FSM and registers only.

Verification
REQ-039 The bench SHALL cover: NUM_BITS=8, STEP=2, a=0x81, shift=3, op SLL -> out_data=0x08, out_valid 3 cycles after the accept.
REQ-040 The bench SHALL cover: a=0x81, shift=3, op SRL -> 0x10; op SRA -> 0xF0.
REQ-041 The bench SHALL cover: DL_SHIFT_ITER_ROTATE_EN defined, a=0x81, shift=3, op ROL -> 0x0C; DL_SHIFT_ITER_ROTATE_EN undefined, same stimulus -> 0x08.
REQ-042 The bench SHALL cover: shift=0, a=0x5A -> out_valid 1 cycle after the accept, out_data=0x5A.
REQ-043 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_data stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-044 The bench SHALL cover: rst_n=0 during SHIFT (a=0xFF, shift=7) -> next edge busy=0, out_valid=0, out_data=0, in_ready=1, and no result is produced.
